// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR: per-channel circular delay lines share one
// time-multiplexed MAC; CPU-writable taps; saturating output with a sticky clip flag.
module fir_decim_mc #(
  parameter int NCH     = 2,
  parameter int NTAPS   = 32,
  parameter int DECIM   = 4,
  parameter int DW      = 18,
  parameter int CW      = 25,
  parameter int SHIFT   = 23,
  parameter int OUT_MAX = 131071,
  parameter int OUT_MIN = -131072
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_din,
  output logic                       busy,
  output logic [31:0]                len,
  input  logic signed [DW-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [($clog2(NCH)|1)-1:0] in_ch,
  output logic signed [DW-1:0]       out_data,
  output logic [($clog2(NCH)|1)-1:0] out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sat,
  input  logic                       sat_clr
);

  localparam int AW  = $clog2(NTAPS);
  localparam int CHW = $clog2(NCH) | 1;
  localparam int TW  = $clog2(NTAPS + 1);
  localparam int DCW = $clog2(DECIM + 1);
  localparam int PW  = DW + CW;
  localparam int ACW = PW + $clog2(NTAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [CW-1:0]  COEF_ONE = CW'(64'(1) << SHIFT);
  localparam logic signed [ACW-1:0] MAX_A    = ACW'(OUT_MAX);
  localparam logic signed [ACW-1:0] MIN_A    = ACW'(OUT_MIN);

  logic [1:0]            state_q, state_d;
  logic [CHW-1:0]        in_ch_q, in_ch_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [DCW-1:0]        dcnt_q, dcnt_d;
  logic [TW-1:0]         tap_q, tap_d;
  logic signed [ACW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]  out_data_q, out_data_d;
  logic [CHW-1:0]        out_ch_q, out_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sat_q, sat_d;
  logic                  rdy_en_q;

  logic signed [DW-1:0]  line_q [NCH][NTAPS];
  logic signed [CW-1:0]  coef_q [NTAPS];
  logic signed [CW-1:0]  coef_f_q;
  logic signed [DW-1:0]  x_f_q;

  logic                  accept, frame_done, decim_done, load_out, fire, clip_hi, clip_lo;
  logic [AW-1:0]         wp_prev;
  logic signed [PW-1:0]  prod;
  logic signed [ACW-1:0] shifted;

  assign in_ready   = rdy_en_q && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign len        = 32'(NTAPS);
  assign in_ch      = in_ch_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign sat        = sat_q;

  assign accept     = in_valid && in_ready;
  assign frame_done = accept && (in_ch_q == CHW'(NCH - 1));
  assign decim_done = frame_done && (dcnt_q == DCW'(DECIM - 1));
  assign wp_prev    = (wp_q == '0) ? AW'(NTAPS - 1) : wp_q - 1'b1;
  assign prod       = coef_f_q * x_f_q;
  assign shifted    = acc_q >>> SHIFT;
  assign clip_hi    = shifted > MAX_A;
  assign clip_lo    = shifted < MIN_A;
  assign load_out   = (state_q == S_OUT) && !out_valid_q;
  assign fire       = out_valid_q && out_ready;

  // NOTE: every signal driven here gets its default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    in_ch_d     = in_ch_q;
    ch_d        = ch_q;
    wp_d        = wp_q;
    rd_d        = rd_q;
    dcnt_d      = dcnt_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (sat_clr) sat_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          in_ch_d = (in_ch_q == CHW'(NCH - 1)) ? '0 : in_ch_q + 1'b1;
          if (frame_done) begin
            wp_d   = (wp_q == AW'(NTAPS - 1)) ? '0 : wp_q + 1'b1;
            dcnt_d = decim_done ? '0 : dcnt_q + 1'b1;
          end
          if (decim_done) begin
            // The completing sample lands at wp_q this edge, so it is the newest tap.
            state_d = S_MAC;
            ch_d    = '0;
            tap_d   = '0;
            rd_d    = wp_q;
          end
        end
      end
      S_MAC: begin
        // Operands fetched in cycle k are accumulated in cycle k+1.
        tap_d = tap_q + 1'b1;
        rd_d  = (rd_q == '0) ? AW'(NTAPS - 1) : rd_q - 1'b1;
        acc_d = (tap_q == '0) ? '0 : acc_q + ACW'(prod);
        if (tap_q == TW'(NTAPS)) state_d = S_OUT;
      end
      S_OUT: begin
        if (load_out) begin
          out_data_d  = clip_hi ? DW'(OUT_MAX) : clip_lo ? DW'(OUT_MIN) : shifted[DW-1:0];
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          if (clip_hi || clip_lo) sat_d = 1'b1;
        end
        if (fire) begin
          out_valid_d = 1'b0;
          if (ch_q == CHW'(NCH - 1)) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_MAC;
            tap_d   = '0;
            rd_d    = wp_prev;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ch_q     <= '0;
      ch_q        <= '0;
      wp_q        <= '0;
      rd_q        <= '0;
      dcnt_q      <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ch_q     <= in_ch_d;
      ch_q        <= ch_d;
      wp_q        <= wp_d;
      rd_q        <= rd_d;
      dcnt_q      <= dcnt_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // NOTE: these arrays are reset on purpose: early samples must read as zero and
  // the coefficient table must come up as an identity filter, so they cannot be RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAPS; t++)
          line_q[c][t] <= '0;
      for (int t = 0; t < NTAPS; t++)
        coef_q[t] <= (t == 0) ? COEF_ONE : '0;
      coef_f_q <= '0;
      x_f_q    <= '0;
    end else begin
      if (accept)
        line_q[in_ch_q][wp_q] <= in_data;
      if (coef_we && (state_q == S_IDLE) && (32'(coef_addr) < NTAPS))
        coef_q[coef_addr] <= coef_din;
      if (state_q == S_MAC) begin
        coef_f_q <= coef_q[tap_q[AW-1:0]];
        x_f_q    <= line_q[ch_q][rd_q];
      end
    end
  end

endmodule
